// File: rtl/mul_seq_pkg.sv
// Shared types and elaboration helpers for the iterative shift-add multiplier sequencer.
package mul_seq_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_e;

    // Bit n set means BPC == n is supported.
    localparam int unsigned LEGAL_BPC_MASK = 32'b0001_0110;

    function automatic int cnt_width(input int width, input int bpc);
        int steps;
        steps = width / bpc;
        return (steps > 1) ? $clog2(steps) : 1;
    endfunction

    function automatic bit bpc_legal(input int width, input int bpc);
        return (bpc > 0) && (bpc < 32) && LEGAL_BPC_MASK[bpc] && ((width % bpc) == 0);
    endfunction

endpackage

// File: rtl/mul_step_dp.sv
// Operand/accumulator registers and the per-step partial-product adder.
module mul_step_dp
    import mul_seq_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int BPC   = 1,
    parameter int CW    = cnt_width(WIDTH, BPC)
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             load_i,
    input  logic             step_i,
    input  logic [WIDTH-1:0] src1_i,
    input  logic [WIDTH-1:0] src2_i,
    input  logic [CW-1:0]    cnt_i,
    output logic [WIDTH-1:0] acc_nxt_o,
    output logic             mreg_zero_o
);

    localparam int SHW = CW + 3;

    logic [WIDTH-1:0] acc_q, acc_d;
    logic [WIDTH-1:0] mreg_q, mreg_d;
    logic [WIDTH-1:0] mcand_q, mcand_d;
    logic [WIDTH-1:0] mbits;
    logic [WIDTH-1:0] pp;
    logic [WIDTH-1:0] acc_step;
    logic [WIDTH-1:0] mreg_shift;
    logic [SHW-1:0]   shamt;

    // Partial product kept at WIDTH bits; anything shifted past the top is dropped.
    always_comb begin
        mbits           = '0;
        mbits[BPC-1:0]  = mreg_q[BPC-1:0];
        pp              = mcand_q * mbits;
        shamt           = SHW'(cnt_i) * SHW'(BPC);
        acc_step        = acc_q + (pp << shamt);
        mreg_shift      = mreg_q >> BPC;

        acc_d   = acc_q;
        mreg_d  = mreg_q;
        mcand_d = mcand_q;
        if (load_i) begin
            acc_d   = '0;
            mreg_d  = src2_i;
            mcand_d = src1_i;
        end else if (step_i) begin
            acc_d  = acc_step;
            mreg_d = mreg_shift;
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            acc_q   <= '0;
            mreg_q  <= '0;
            mcand_q <= '0;
        end else begin
            acc_q   <= acc_d;
            mreg_q  <= mreg_d;
            mcand_q <= mcand_d;
        end
    end

    assign acc_nxt_o   = acc_step;
    assign mreg_zero_o = (mreg_shift == '0);

endmodule

// File: rtl/mul_seq_ctrl.sv
// Multi-cycle multiply sequencer: stalls the PC while the datapath iterates,
// then emits a one-cycle writeback strobe with the truncated product.
module mul_seq_ctrl
    import mul_seq_pkg::*;
#(
    parameter int WIDTH      = 32,
    parameter int BPC        = 1,
    parameter int EARLY_TERM = 1
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             start_i,
    input  logic             abort_i,
    input  logic [WIDTH-1:0] src1_i,
    input  logic [WIDTH-1:0] src2_i,
    output logic             busy_o,
    output logic             stall_o,
    output logic             done_o,
    output logic             wb_en_o,
    output logic [WIDTH-1:0] result_o
);

    localparam int            CW       = cnt_width(WIDTH, BPC);
    localparam logic [CW-1:0] LAST_CNT = CW'(WIDTH / BPC - 1);

    if (!bpc_legal(WIDTH, BPC)) begin : g_bad_bpc
        $error("mul_seq_ctrl: BPC must be 1, 2 or 4 and divide WIDTH");
    end

    state_e           state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] result_q, result_d;
    logic             load, step, finish;
    logic [WIDTH-1:0] acc_nxt;
    logic             mreg_zero;

    mul_step_dp #(
        .WIDTH (WIDTH),
        .BPC   (BPC),
        .CW    (CW)
    ) u_dp (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .load_i      (load),
        .step_i      (step),
        .src1_i      (src1_i),
        .src2_i      (src2_i),
        .cnt_i       (cnt_q),
        .acc_nxt_o   (acc_nxt),
        .mreg_zero_o (mreg_zero)
    );

    assign finish = (cnt_q == LAST_CNT) || ((EARLY_TERM != 0) && mreg_zero);

    // DONE always returns to IDLE so a start held for the same instruction cannot re-issue.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        result_d = result_q;
        load     = 1'b0;
        step     = 1'b0;
        case (state_q)
            IDLE: begin
                if (start_i && !abort_i) begin
                    load    = 1'b1;
                    cnt_d   = '0;
                    state_d = RUN;
                end
            end
            RUN: begin
                if (abort_i) begin
                    state_d = IDLE;
                end else begin
                    step  = 1'b1;
                    cnt_d = cnt_q + 1'b1;
                    if (finish) begin
                        state_d  = DONE;
                        result_d = acc_nxt;
                    end
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            result_q <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            result_q <= result_d;
        end
    end

    assign busy_o   = (state_q != IDLE);
    assign stall_o  = (state_q == RUN) || ((state_q == IDLE) && start_i);
    assign done_o   = (state_q == DONE) && !abort_i;
    assign wb_en_o  = done_o;
    assign result_o = result_q;

endmodule
